// File: rtl/div_if.sv
// Handshake and operand bundle between execute-stage control and the divide unit.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             is_rem;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             zero;

    modport master (
        output start, is_signed, is_rem, a, b,
        input  busy, done, y, zero
    );

    modport slave (
        input  start, is_signed, is_rem, a, b,
        output busy, done, y, zero
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M-style divide/remainder unit: restoring radix-2, one quotient
// bit per cycle, sign fixup in a final cycle.
//
//   state | meaning
//   IDLE  | waiting for start; y/zero hold the last result
//   CALC  | one restoring iteration per cycle, WIDTH cycles
//   FIX   | sign fixup, register y/zero, pulse done
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             rem_sel;
    logic             special;
    logic             done_r;
    logic [WIDTH-1:0] y_r;
    logic             zero_r;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] res;

    always_comb begin
        abs_a = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        abs_b = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    end

    // The extra remainder bit keeps the trial subtraction's sign visible.
    always_comb begin
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
    end

    always_comb begin
        res = '0;
        if (rem_sel) begin
            res = rem[WIDTH-1:0];
            if (neg_r && !special) res = ~rem[WIDTH-1:0] + 1'b1;
        end else begin
            res = quo;
            if (neg_q && !special) res = ~quo + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
            special <= 1'b0;
            done_r  <= 1'b0;
            y_r     <= '0;
            zero_r  <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem_sel <= bus.is_rem;
                        neg_q   <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r   <= bus.is_signed & bus.a[WIDTH-1];
                        count   <= CW'(WIDTH);
                        if (bus.b == '0) begin
                            special <= 1'b1;
                            quo     <= '1;
                            rem     <= {1'b0, bus.a};
                            state   <= FIX;
                        end else if (bus.is_signed && bus.a == MIN_NEG && bus.b == '1) begin
                            special <= 1'b1;
                            quo     <= bus.a;
                            rem     <= '0;
                            state   <= FIX;
                        end else begin
                            special <= 1'b0;
                            quo     <= abs_a;
                            dvs     <= abs_b;
                            rem     <= '0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= FIX;
                end
                FIX: begin
                    y_r    <= res;
                    zero_r <= (res == '0);
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.y    = y_r;
    assign bus.zero = zero_r;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed RV32M results, latencies and control corner cases.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    div_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; start is sampled on the next edge.
    task automatic launch(input logic sg, input logic rm, input logic [31:0] av, input logic [31:0] bv);
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.is_rem    = rm;
        bus.a         = av;
        bus.b         = bv;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // lat = number of edges after the start edge until done is seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 0;
        busy_cyc = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic sg, input logic rm,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_y, input int exp_lat);
        int lat, bc;
        launch(sg, rm, av, bv);
        wait_done(lat, bc);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_y"}, bus.y, exp_y);
        check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_y == 32'd0});
        @(posedge clk); #1;
        check({tag, "_done_once"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        tests = 0;
        fails = 0;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.is_rem = 1'b0;
        bus.a = '0; bus.b = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_y", bus.y, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned 100/7 with busy-length check
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        wait_done(lat, bc);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_busy", 32'(bc), 32'd33);
        check("divu_y", bus.y, 32'd14);
        check("divu_zero", {31'd0, bus.zero}, 32'd0);
        check("divu_busy_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        run_op("remu", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33);
        run_op("rem_neg", 1'b1, 1'b1, -32'sd20, 32'd3, 32'hFFFFFFFE, 33);
        run_op("div_neg", 1'b1, 1'b0, -32'sd20, 32'd3, 32'hFFFFFFFA, 33);
        run_op("div_negb", 1'b1, 1'b0, 32'd7, -32'sd2, 32'hFFFFFFFD, 33);
        run_op("rem_negb", 1'b1, 1'b1, 32'd7, -32'sd2, 32'd1, 33);
        run_op("divu_big", 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33);
        run_op("remu_big", 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd1, 33);
        run_op("divu_zero_q", 1'b0, 1'b0, 32'd5, 32'd9, 32'd0, 33);
        run_op("div0_q", 1'b0, 1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 1);
        run_op("div0_r", 1'b0, 1'b1, 32'd1234, 32'd0, 32'd1234, 1);
        run_op("div0_sr", 1'b1, 1'b1, -32'sd5, 32'd0, 32'hFFFFFFFB, 1);
        run_op("ovf_q", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("ovf_r", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        run_op("divu_minm1", 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);

        // Start while busy is ignored; start in the done cycle is accepted
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3; bus.is_rem = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("ign_lat", 32'(lat + 4), 32'd33);
        check("ign_y", bus.y, 32'd14);
        launch(1'b0, 1'b0, 32'd9, 32'd3);
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_done_low", {31'd0, bus.done}, 32'd0);
        check("b2b_y_hold", bus.y, 32'd14);
        wait_done(lat, bc);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_y", bus.y, 32'd3);
        @(posedge clk); #1;

        // Reset mid-operation
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        check("mrst_y", bus.y, 32'd0);
        check("mrst_zero", {31'd0, bus.zero}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("mrst_no_done", 32'(ndone), 32'd0);
        run_op("post_rst", 1'b1, 1'b0, -32'sd100, 32'd7, 32'hFFFFFFF2, 33);
        run_op("post_rst_r", 1'b1, 1'b1, -32'sd100, 32'd7, 32'hFFFFFFFE, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle integer divide/remainder unit in the execute stage, beside the ALU. It takes the same decoded a/b operands the ALU consumes. Its result is muxed with the ALU y output ahead of writeback.
Control asserts start for DIV/DIVU/REM/REMU and stalls PC/regfile writes while busy is high. Results follow RV32M semantics.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new operation; sampled only in IDLE.
is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start.
is_rem  input  1  1 = return remainder, 0 = return quotient; sampled with start.
a  input  WIDTH  dividend; sampled with start.
b  input  WIDTH  divisor; sampled with start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; y valid in that cycle and held afterwards.
y  output  WIDTH  quotient or remainder.
zero  output  1  y == 0, same meaning as the ALU zero flag.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). rst_n low forces state=IDLE, busy=0, done=0, y=0, zero=1 and clears all internal registers.
- Reset mid-operation aborts the operation. No done pulse is produced. After release, the unit accepts start in the first cycle.
- FSM states: IDLE, CALC, FIX.
- IDLE + start (edge k):
  - latch is_signed, is_rem and the operand magnitudes (absolute values when signed).
  - record neg_q = sign(a)^sign(b) and neg_r = sign(a) (signed mode only).
  - clear the remainder register, load counter = WIDTH, go to CALC.
- Special cases are detected at edge k and go straight to FIX with the result preloaded:
  - b == 0: quotient = all ones, remainder = a.
  - signed, a == 2^(WIDTH-1) and b == -1: quotient = a, remainder = 0.
- CALC: restoring radix-2, one quotient bit per cycle, MSB first.
  - shift {rem, dividend} left by 1; trial = rem - divisor.
  - if trial is non-negative: rem = trial and the quotient bit is 1; otherwise the bit is 0.
  - the remainder datapath is WIDTH+1 bits wide so the trial sign bit is never lost.
  - counter decrements each cycle; after WIDTH iterations go to FIX.
- FIX:
  - apply sign fixups: negate the quotient if neg_q; negate the remainder if neg_r. Special-case results skip fixup.
  - register y and zero, assert done for exactly one cycle, go to IDLE.
- Latency, start sampled at edge k:
  - normal operation: done high after edge k+WIDTH+1 (33 cycles for WIDTH=32).
  - special cases: done high after edge k+1.
- start while busy is ignored; operand and control changes while busy have no effect.
- Back-to-back: start may be asserted in the cycle done is high (state is IDLE) and is accepted.
- y and zero change only at the FIX edge or at reset; they hold between operations.
- busy is decoded combinationally from the state register. done, y and zero are registered.

Test Plan:
- Unsigned quotient: start, is_signed=0, is_rem=0, a=100, b=7 -> done 33 cycles later, y=14, zero=0, busy high for 33 cycles.
- Signed remainder and quotient: is_signed=1, is_rem=1, a=-20, b=3 -> y=-2 (0xFFFFFFFE). Repeat with is_rem=0 -> y=-6 (0xFFFFFFFA).
- Divide by zero, unsigned: a=1234, b=0, is_rem=0 -> done after 1 cycle, y=0xFFFFFFFF. With is_rem=1 -> y=1234.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> quotient y=0x80000000; remainder y=0 with zero=1; done after 1 cycle.
- Start while busy: second start with a=9, b=3 at cycle 5 of a 100/7 operation -> ignored; only one done, y=14. Then start in the done cycle with a=9, b=3 -> accepted, y=3 after 33 more cycles.
- Reset mid-operation: drop rst_n at cycle 10 of an operation -> busy=0, done=0, y=0 immediately. No done pulse follows. A new start after release gives a correct result.
